accel_queued_alu: RTL and testbench



---
 rtl/accel_queued_alu_if.sv | 11 +
 rtl/accel_queued_alu.sv | 179 +++++++++++++++++
 tb/tb_accel_queued_alu.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_queued_alu_if.sv
// Peripheral bus between the TinyQV host and the queued ALU: 4-bit address, 8-bit data,
// single write strobe and combinational read data.
interface accel_queued_alu_if;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output address, data_write, data_in, input data_out);
  modport slave  (input address, data_write, data_in, output data_out);
endinterface

// File: rtl/accel_queued_alu.sv
// Queued ALU peripheral: register file, instruction queue fed by OP/SRC/DEST staging writes,
// and a sequencer running single-cycle ALU ops or an 8-cycle shift-add multiply.
module accel_queued_alu #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           ui_in,
  output logic [7:0]           uo_out,
  accel_queued_alu_if.slave    bus
);
  localparam int unsigned IdxW = $clog2(NUM_REGS);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned EntW = 4 + 3 * IdxW;

  typedef enum logic [1:0] {StIdle, StExec, StMul} state_e;

  logic [7:0]      regs_q [NUM_REGS];
  logic [3:0]      op_q;
  logic [IdxW-1:0] src_a_q, src_b_q, dest_q;
  logic [EntW-1:0] queue_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            err_q;

  state_e          state_q;
  logic [3:0]      cur_op_q;
  logic [IdxW-1:0] cur_dest_q;
  logic [7:0]      opa_q, opb_q, acc_q;
  logic [2:0]      mul_cnt_q;

  logic unused_ui;
  assign unused_ui = ^ui_in;

  logic reg_sel, wr_reg, wr_op, wr_src, wr_dest, wr_status;
  assign reg_sel   = {28'd0, bus.address} < NUM_REGS;
  assign wr_reg    = bus.data_write && reg_sel;
  assign wr_op     = bus.data_write && (bus.address == 4'hC);
  assign wr_src    = bus.data_write && (bus.address == 4'hD);
  assign wr_dest   = bus.data_write && (bus.address == 4'hE);
  assign wr_status = bus.data_write && (bus.address == 4'hF);

  logic full, empty, busy, pop, push_ok, push_drop, flush, err_clr;
  assign full      = count_q == CntW'(DEPTH);
  assign empty     = count_q == '0;
  assign busy      = !(state_q == StIdle && empty);
  assign pop       = (state_q == StIdle) && !empty;
  // A pop frees a slot in the same cycle, so a push onto a full queue still lands.
  assign push_ok   = wr_dest && (!full || pop);
  assign push_drop = wr_dest && full && !pop;
  assign flush     = wr_status && bus.data_in[0];
  assign err_clr   = wr_status && bus.data_in[1];

  logic [EntW-1:0] head;
  logic [3:0]      head_op;
  logic [IdxW-1:0] head_a, head_b, head_dest;
  logic            head_illegal;
  assign head         = queue_q[rd_ptr_q];
  assign head_op      = head[EntW-1 -: 4];
  assign head_a       = head[3*IdxW-1 -: IdxW];
  assign head_b       = head[2*IdxW-1 -: IdxW];
  assign head_dest    = head[IdxW-1:0];
  assign head_illegal = head_op > 4'd9;

  logic [7:0] exec_res, mul_acc_next, eng_val;
  logic       exec_we, eng_we;

  always_comb begin
    exec_res = '0;
    exec_we  = 1'b1;
    case (cur_op_q)
      4'd1:    exec_res = opa_q + opb_q;
      4'd2:    exec_res = opa_q - opb_q;
      4'd3:    exec_res = opa_q & opb_q;
      4'd4:    exec_res = opa_q | opb_q;
      4'd5:    exec_res = opa_q ^ opb_q;
      4'd6:    exec_res = opa_q << opb_q[2:0];
      4'd7:    exec_res = opa_q >> opb_q[2:0];
      4'd9:    exec_res = opa_q;
      default: exec_we  = 1'b0;
    endcase
  end

  assign mul_acc_next = acc_q + (opb_q[mul_cnt_q] ? (opa_q << mul_cnt_q) : 8'd0);
  assign eng_we  = (state_q == StExec && exec_we) || (state_q == StMul && mul_cnt_q == 3'd7);
  assign eng_val = (state_q == StMul) ? mul_acc_next : exec_res;

  // Register file, staging, queue and error flag. Engine writeback is applied last so it
  // overrides a same-cycle bus write to the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      op_q     <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      dest_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (wr_reg) regs_q[bus.address[IdxW-1:0]] <= bus.data_in;
      if (eng_we) regs_q[cur_dest_q] <= eng_val;
      if (wr_op) op_q <= bus.data_in[3:0];
      if (wr_src) begin
        src_a_q <= bus.data_in[IdxW-1:0];
        src_b_q <= bus.data_in[4 +: IdxW];
      end
      if (wr_dest) dest_q <= bus.data_in[IdxW-1:0];
      if (push_ok) begin
        queue_q[wr_ptr_q] <= {op_q, src_a_q, src_b_q, bus.data_in[IdxW-1:0]};
        wr_ptr_q          <= wr_ptr_q + PtrW'(1);
      end
      if (flush) begin
        rd_ptr_q <= wr_ptr_q;
        count_q  <= '0;
      end else begin
        if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
        count_q <= count_q + CntW'(push_ok) - CntW'(pop);
      end
      err_q <= (err_q && !err_clr) || push_drop || (pop && head_illegal);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cur_op_q   <= '0;
      cur_dest_q <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      mul_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            cur_op_q   <= head_op;
            cur_dest_q <= head_dest;
            opa_q      <= regs_q[head_a];
            opb_q      <= regs_q[head_b];
            acc_q      <= '0;
            mul_cnt_q  <= '0;
            state_q    <= (head_op == 4'd8) ? StMul : StExec;
          end
        end
        StExec: state_q <= StIdle;
        StMul: begin
          acc_q     <= mul_acc_next;
          mul_cnt_q <= mul_cnt_q + 3'd1;
          if (mul_cnt_q == 3'd7) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.data_out = '0;
    if (reg_sel) begin
      bus.data_out = regs_q[bus.address[IdxW-1:0]];
    end else begin
      case (bus.address)
        4'hC: bus.data_out[3:0] = op_q;
        4'hD: begin
          bus.data_out[IdxW-1:0] = src_a_q;
          bus.data_out[4 +: IdxW] = src_b_q;
        end
        4'hE: bus.data_out[IdxW-1:0] = dest_q;
        4'hF: bus.data_out = {4'(count_q), full, empty, busy, err_q};
        default: bus.data_out = '0;
      endcase
    end
  end

  assign uo_out = {busy, err_q, 6'b0};
endmodule

// File: tb/tb_accel_queued_alu.sv
// Directed bench for accel_queued_alu with hand-computed expectations.
module tb_accel_queued_alu;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;
  int checks = 0;
  int errors = 0;

  localparam logic [3:0] ALU_OPS [8] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd1, 4'd0};
  localparam logic [7:0] ALU_EXP [8] = '{8'h12, 8'hFF, 8'hED, 8'hB0, 8'h16, 8'hB6, 8'h11, 8'h11};

  accel_queued_alu_if bus ();

  accel_queued_alu #(.NUM_REGS(4), .DEPTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .ui_in (ui_in),
    .uo_out(uo_out),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.address    = a;
    bus.data_in    = d;
    bus.data_write = 1'b1;
    @(posedge clk);
    #1;
    bus.data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    bus.address = a;
    #1;
    d = bus.data_out;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1;
    bus.data_write = 1'b0;
    bus.address = 4'h0;
    bus.data_in = 8'h00;
    step(2);
    rst = 1'b0;
    checks++;
    if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo: got %h want 00", uo_out); end
    rd(4'hF, d);
    checks++;
    if (d !== 8'h04) begin errors++; $display("FAIL reset_status: got %h want 04", d); end
    rd(4'h0, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_r0: got %h want 00", d); end
    wr(4'h5, 8'hFF);
    rd(4'h5, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reserved_5: got %h want 00", d); end
    wr(4'hB, 8'hFF);
    rd(4'hB, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reserved_b: got %h want 00", d); end
  endtask

  task automatic test_add();
    logic [7:0] d;
    wr(4'h0, 8'h10);
    wr(4'h1, 8'h25);
    wr(4'hC, 8'h01);
    wr(4'hD, 8'h10);
    wr(4'hE, 8'h02);
    checks++;
    if (uo_out[7] !== 1'b1) begin errors++; $display("FAIL add_busy_t0: got %b want 1", uo_out[7]); end
    rd(4'h2, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL add_early_t0: got %h want 00", d); end
    step(1);
    rd(4'h2, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL add_early_t1: got %h want 00", d); end
    checks++;
    if (uo_out[7] !== 1'b1) begin errors++; $display("FAIL add_busy_t1: got %b want 1", uo_out[7]); end
    step(1);
    rd(4'h2, d);
    checks++;
    if (d !== 8'h35) begin errors++; $display("FAIL add_result: got %h want 35", d); end
    checks++;
    if (uo_out !== 8'h00) begin errors++; $display("FAIL add_idle_uo: got %h want 00", uo_out); end
    rd(4'hF, d);
    checks++;
    if (d !== 8'h04) begin errors++; $display("FAIL add_status: got %h want 04", d); end
    rd(4'hD, d);
    checks++;
    if (d !== 8'h10) begin errors++; $display("FAIL src_readback: got %h want 10", d); end
    rd(4'hE, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL dest_readback: got %h want 02", d); end
  endtask

  task automatic test_mul();
    logic [7:0] d;
    wr(4'h0, 8'h13);
    wr(4'h1, 8'h11);
    wr(4'hC, 8'h08);
    wr(4'hD, 8'h10);
    wr(4'hE, 8'h03);
    step(8);
    rd(4'h3, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL mul_early: got %h want 00", d); end
    step(1);
    rd(4'h3, d);
    checks++;
    if (d !== 8'h43) begin errors++; $display("FAIL mul_result: got %h want 43", d); end
    wr(4'h0, 8'h05);
    wr(4'h1, 8'h07);
    wr(4'hC, 8'h02);
    wr(4'hE, 8'h03);
    step(2);
    rd(4'h3, d);
    checks++;
    if (d !== 8'hFE) begin errors++; $display("FAIL sub_wrap: got %h want fe", d); end
  endtask

  task automatic test_alu_ops();
    logic [7:0] d;
    wr(4'h0, 8'hB6);
    wr(4'h1, 8'h5B);
    wr(4'hD, 8'h10);
    for (int i = 0; i < 8; i++) begin
      wr(4'hC, {4'h0, ALU_OPS[i]});
      wr(4'hE, 8'h03);
      step(2);
      rd(4'h3, d);
      checks++;
      if (d !== ALU_EXP[i]) begin
        errors++;
        $display("FAIL alu_op_%0d: got %h want %h", ALU_OPS[i], d, ALU_EXP[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    wr(4'h0, 8'h01);
    wr(4'hC, 8'h01);
    wr(4'hD, 8'h00);
    for (int i = 0; i < 4; i++) wr(4'hE, 8'h00);
    rd(4'hF, d);
    checks++;
    if (d !== 8'h22) begin errors++; $display("FAIL chain_status_mid: got %h want 22", d); end
    step(4);
    rd(4'h0, d);
    checks++;
    if (d !== 8'h08) begin errors++; $display("FAIL chain_r0_mid: got %h want 08", d); end
    step(1);
    rd(4'h0, d);
    checks++;
    if (d !== 8'h10) begin errors++; $display("FAIL chain_r0_final: got %h want 10", d); end
    rd(4'hF, d);
    checks++;
    if (d !== 8'h04) begin errors++; $display("FAIL chain_status_end: got %h want 04", d); end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    wr(4'hC, 8'h08);
    wr(4'hD, 8'h10);
    for (int i = 0; i < 6; i++) wr(4'hE, 8'h03);
    rd(4'hF, d);
    checks++;
    if (d !== 8'h4B) begin errors++; $display("FAIL ovf_status: got %h want 4b", d); end
    checks++;
    if (uo_out !== 8'hC0) begin errors++; $display("FAIL ovf_uo: got %h want c0", uo_out); end
    wr(4'hF, 8'h02);
    checks++;
    if (uo_out !== 8'h80) begin errors++; $display("FAIL err_clear_uo: got %h want 80", uo_out); end
    rd(4'hF, d);
    checks++;
    if (d !== 8'h4A) begin errors++; $display("FAIL err_clear_status: got %h want 4a", d); end
    wr(4'hF, 8'h01);
    rd(4'hF, d);
    checks++;
    if (d !== 8'h06) begin errors++; $display("FAIL ovf_flush_status: got %h want 06", d); end
    step(3);
    rd(4'hF, d);
    checks++;
    if (d !== 8'h04) begin errors++; $display("FAIL ovf_drain_status: got %h want 04", d); end
  endtask

  task automatic test_illegal_flush();
    logic [7:0] d;
    wr(4'h0, 8'h11);
    wr(4'h1, 8'h22);
    wr(4'h2, 8'h55);
    wr(4'hC, 8'h0B);
    wr(4'hD, 8'h10);
    wr(4'hE, 8'h02);
    step(2);
    rd(4'h2, d);
    checks++;
    if (d !== 8'h55) begin errors++; $display("FAIL illegal_no_wb: got %h want 55", d); end
    checks++;
    if (uo_out !== 8'h40) begin errors++; $display("FAIL illegal_err_uo: got %h want 40", uo_out); end
    wr(4'hF, 8'h02);
    wr(4'hC, 8'h08);
    wr(4'hE, 8'h03);
    wr(4'hC, 8'h01);
    for (int i = 0; i < 3; i++) wr(4'hE, 8'h02);
    rd(4'hF, d);
    checks++;
    if (d !== 8'h32) begin errors++; $display("FAIL flush_pre_status: got %h want 32", d); end
    wr(4'hF, 8'h01);
    step(4);
    rd(4'h3, d);
    checks++;
    if (d !== 8'h42) begin errors++; $display("FAIL flush_mul_lands: got %h want 42", d); end
    step(4);
    rd(4'h2, d);
    checks++;
    if (d !== 8'h55) begin errors++; $display("FAIL flush_discarded: got %h want 55", d); end
    rd(4'hF, d);
    checks++;
    if (d !== 8'h04) begin errors++; $display("FAIL flush_status: got %h want 04", d); end
  endtask

  task automatic test_conflict();
    logic [7:0] d;
    wr(4'h0, 8'h10);
    wr(4'h1, 8'h25);
    wr(4'hC, 8'h01);
    wr(4'hD, 8'h10);
    wr(4'hE, 8'h02);
    step(1);
    wr(4'h2, 8'hAA);
    rd(4'h2, d);
    checks++;
    if (d !== 8'h35) begin errors++; $display("FAIL conflict_same: got %h want 35", d); end
    wr(4'h2, 8'h00);
    wr(4'hE, 8'h02);
    step(1);
    wr(4'h1, 8'h99);
    rd(4'h1, d);
    checks++;
    if (d !== 8'h99) begin errors++; $display("FAIL conflict_other_bus: got %h want 99", d); end
    rd(4'h2, d);
    checks++;
    if (d !== 8'h35) begin errors++; $display("FAIL conflict_other_eng: got %h want 35", d); end
  endtask

  task automatic test_reset_mul();
    logic [7:0] d;
    wr(4'hC, 8'h08);
    wr(4'hE, 8'h03);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if (uo_out !== 8'h00) begin errors++; $display("FAIL rst_mul_uo: got %h want 00", uo_out); end
    for (int i = 0; i < 4; i++) begin
      rd(4'(i), d);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL rst_mul_r%0d: got %h want 00", i, d); end
    end
    step(10);
    rd(4'h3, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL rst_mul_no_wb: got %h want 00", d); end
    rd(4'hF, d);
    checks++;
    if (d !== 8'h04) begin errors++; $display("FAIL rst_mul_status: got %h want 04", d); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_alu_ops();
    test_back_to_back();
    test_overflow();
    test_illegal_flush();
    test_conflict();
    test_reset_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
